// File: rtl/gp_engine_pkg.sv
// Shared types and AHB-Lite encodings for the GP engine configuration path.
package gp_engine_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WDATA = 3'd1,
    REQ   = 3'd2,
    DONE  = 3'd3,
    ERR1  = 3'd4,
    ERR2  = 3'd5
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/gp_ahb_reg_bridge_if.sv
// AHB-Lite slave port plus register-file request port of the bridge.
interface gp_ahb_reg_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  // AHB-Lite side
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;
  // Register-file side
  logic                  slv_o_valid;
  logic [DATA_WIDTH-1:0] slv_i_wr_data;
  logic [ADDR_WIDTH-1:0] slv_i_addr;
  logic                  slv_i_rd0_wr1;
  logic                  slv_i_ready;
  logic [DATA_WIDTH-1:0] slv_o_read_data;
  logic                  slv_o_rd_valid;

  // Bridge view
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output slv_o_valid, slv_i_wr_data, slv_i_addr, slv_i_rd0_wr1,
    input  slv_i_ready, slv_o_read_data, slv_o_rd_valid
  );

  // Bus master / register-file view
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  slv_o_valid, slv_i_wr_data, slv_i_addr, slv_i_rd0_wr1,
    output slv_i_ready, slv_o_read_data, slv_o_rd_valid
  );

endinterface

// File: rtl/gp_ahb_reg_bridge.sv
// AHB-Lite slave that turns each transfer into one register-file request,
// stretching the data phase until the register file answers or times out.
module gp_ahb_reg_bridge
  import gp_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_SPAN       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  gp_ahb_reg_bridge_if.slave  bus
);

  localparam int unsigned           CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(REG_SPAN);

  bridge_state_e         r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rd0_wr1;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_valid;
  logic                  r_hreadyout;
  logic                  r_hresp;

  bridge_state_e         w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_rd0_wr1_nxt;
  logic [DATA_WIDTH-1:0] w_wr_data_nxt;
  logic [DATA_WIDTH-1:0] w_rd_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_hreadyout_nxt;
  logic                  w_hresp_nxt;
  logic                  w_active;
  logic                  w_accept;
  logic                  w_legal;

  // Transfer qualification: only NONSEQ/SEQ with select and bus ready are taken
  assign w_active = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
  assign w_accept = bus.HSEL && bus.HREADY && w_active;
  assign w_legal  = (bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] == 2'b00) &&
                    (bus.HADDR < SPAN);

  // Next-state, datapath and output decode; outputs follow the next state
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = r_addr;
    w_rd0_wr1_nxt = r_rd0_wr1;
    w_wr_data_nxt = r_wr_data;
    w_rd_data_nxt = r_rd_data;

    case (r_state)
      IDLE, DONE, ERR2: begin
        w_state_nxt = IDLE;
        if (w_accept) begin
          if (!w_legal) begin
            w_state_nxt = ERR1;
          end else begin
            w_addr_nxt    = bus.HADDR;
            w_rd0_wr1_nxt = bus.HWRITE;
            w_cnt_nxt     = '0;
            w_state_nxt   = bus.HWRITE ? WDATA : REQ;
          end
        end
      end
      WDATA: begin
        w_wr_data_nxt = bus.HWDATA;
        w_cnt_nxt     = '0;
        w_state_nxt   = REQ;
      end
      REQ: begin
        // A response in the expiry cycle still wins over the timeout
        if (r_rd0_wr1 && bus.slv_i_ready) begin
          w_state_nxt = DONE;
        end else if (!r_rd0_wr1 && bus.slv_o_rd_valid) begin
          w_rd_data_nxt = bus.slv_o_read_data;
          w_state_nxt   = DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ERR1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ERR1:    w_state_nxt = ERR2;
      default: w_state_nxt = IDLE;
    endcase

    w_valid_nxt     = (w_state_nxt == REQ);
    w_hreadyout_nxt = (w_state_nxt == IDLE) || (w_state_nxt == DONE) ||
                      (w_state_nxt == ERR2);
    w_hresp_nxt     = ((w_state_nxt == ERR1) || (w_state_nxt == ERR2)) ?
                      HRESP_ERROR : HRESP_OKAY;
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_rd0_wr1   <= 1'b0;
      r_wr_data   <= '0;
      r_rd_data   <= '0;
      r_valid     <= 1'b0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_rd0_wr1   <= w_rd0_wr1_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_valid     <= w_valid_nxt;
      r_hreadyout <= w_hreadyout_nxt;
      r_hresp     <= w_hresp_nxt;
    end
  end

  assign bus.HREADYOUT     = r_hreadyout;
  assign bus.HRESP         = r_hresp;
  assign bus.HRDATA        = r_rd_data;
  assign bus.slv_o_valid   = r_valid;
  assign bus.slv_i_wr_data = r_wr_data;
  assign bus.slv_i_addr    = r_addr;
  assign bus.slv_i_rd0_wr1 = r_rd0_wr1;

endmodule
